// File: rtl/bitmanip_seq_if.sv
// Request/response bundle for the bit extract/deposit sequencer.
// The slave side is the sequencer; the master side is the requester and consumer.
interface bitmanip_seq_if #(
    parameter int TRANS_ID_BITS = 3
);
    logic                     flush_i;
    logic                     valid_i;
    logic                     ready_o;
    logic                     op_i;
    logic [63:0]              operand_a_i;
    logic [63:0]              mask_i;
    logic [TRANS_ID_BITS-1:0] trans_id_i;
    logic                     valid_o;
    logic [63:0]              result_o;
    logic [TRANS_ID_BITS-1:0] trans_id_o;

    modport master (
        output flush_i, valid_i, op_i, operand_a_i, mask_i, trans_id_i,
        input  ready_o, valid_o, result_o, trans_id_o
    );

    modport slave (
        input  flush_i, valid_i, op_i, operand_a_i, mask_i, trans_id_i,
        output ready_o, valid_o, result_o, trans_id_o
    );
endinterface

// File: rtl/bitmanip_seq.sv
// Sequential BEXT/BDEP unit: one mask bit per cycle, latency popcount(mask)+1.
//   state | meaning
//   IDLE  | waiting for a request, ready_o high unless flushing
//   BUSY  | consuming the lowest set bit of the held mask each cycle
//   DONE  | result presented for exactly one cycle
module bitmanip_seq #(
    parameter int TRANS_ID_BITS = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    bitmanip_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                   r_state;
    logic                     r_op;
    logic [63:0]              r_a;
    logic [63:0]              r_mask;
    logic [63:0]              r_acc;
    logic [6:0]               r_cnt;
    logic [TRANS_ID_BITS-1:0] r_tag;

    logic [63:0] w_low;
    logic [63:0] w_mask_next;
    logic [63:0] w_acc_next;
    logic        w_a_at_mask;
    logic        w_a_at_cnt;

    // w_low isolates the lowest set mask bit, so a[p] and acc[p] need no encoder.
    assign w_low       = r_mask & (~r_mask + 64'd1);
    assign w_mask_next = r_mask & (r_mask - 64'd1);
    assign w_a_at_mask = |(r_a & w_low);
    assign w_a_at_cnt  = |(r_a & (64'd1 << r_cnt));

    always_comb begin
        w_acc_next = r_acc;
        if (r_op)
            w_acc_next = r_acc | (w_a_at_cnt ? w_low : 64'd0);
        else
            w_acc_next = r_acc | ({63'd0, w_a_at_mask} << r_cnt);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_op    <= 1'b0;
            r_a     <= '0;
            r_mask  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_tag   <= '0;
        end else if (bus.flush_i) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.valid_i) begin
                        r_op    <= bus.op_i;
                        r_a     <= bus.operand_a_i;
                        r_mask  <= bus.mask_i;
                        r_tag   <= bus.trans_id_i;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= (bus.mask_i != 64'd0) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    r_acc  <= w_acc_next;
                    r_cnt  <= r_cnt + 7'd1;
                    r_mask <= w_mask_next;
                    if (w_mask_next == 64'd0)
                        r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Flush must kill handshakes within the same cycle, hence the gating here.
    assign bus.ready_o    = (r_state == IDLE) && !bus.flush_i;
    assign bus.valid_o    = (r_state == DONE) && !bus.flush_i;
    assign bus.result_o   = bus.valid_o ? r_acc : 64'd0;
    assign bus.trans_id_o = bus.valid_o ? r_tag : '0;
endmodule

// File: tb/tb_bitmanip_seq.sv
// Self-checking bench for bitmanip_seq: directed corner cases plus random
// operations compared against a bit-loop reference model.
module tb_bitmanip_seq;
    localparam int TB = 3;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    bitmanip_seq_if #(.TRANS_ID_BITS(TB)) bus ();

    bitmanip_seq #(.TRANS_ID_BITS(TB)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_bext(input logic [63:0] a, input logic [63:0] m);
        logic [63:0] r;
        int k;
        r = '0;
        k = 0;
        for (int i = 0; i < 64; i++)
            if (m[i]) begin
                r[k] = a[i];
                k++;
            end
        return r;
    endfunction

    function automatic logic [63:0] ref_bdep(input logic [63:0] a, input logic [63:0] m);
        logic [63:0] r;
        int k;
        r = '0;
        k = 0;
        for (int i = 0; i < 64; i++)
            if (m[i]) begin
                r[i] = a[k];
                k++;
            end
        return r;
    endfunction

    task automatic scramble();
        bus.valid_i     = 1'($urandom_range(0, 1));
        bus.op_i        = 1'($urandom_range(0, 1));
        bus.operand_a_i = {$urandom, $urandom};
        bus.mask_i      = {$urandom, $urandom};
        bus.trans_id_i  = TB'($urandom);
    endtask

    // Issues one request and checks every cycle until the result, a flush or a reset.
    task automatic run_op(input logic op, input logic [63:0] a, input logic [63:0] m,
                          input logic [TB-1:0] tag, input int flush_at, input int rst_at,
                          input logic use_exp, input logic [63:0] exp_in);
        int          n;
        logic [63:0] exp;
        logic        last;
        n   = $countones(m);
        exp = use_exp ? exp_in : (op ? ref_bdep(a, m) : ref_bext(a, m));
        @(negedge clk_i);
        bus.flush_i     = 1'b0;
        bus.valid_i     = 1'b1;
        bus.op_i        = op;
        bus.operand_a_i = a;
        bus.mask_i      = m;
        bus.trans_id_i  = tag;
        #1;
        chk("ready_idle", 64'(bus.ready_o), 64'd1);
        chk("valid_idle", 64'(bus.valid_o), 64'd0);
        @(posedge clk_i);
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk_i);
            scramble();
            if (k == flush_at) begin
                bus.flush_i = 1'b1;
                #1;
                chk("flush_valid", 64'(bus.valid_o), 64'd0);
                chk("flush_ready", 64'(bus.ready_o), 64'd0);
                chk("flush_result", bus.result_o, 64'd0);
                return;
            end
            if (k == rst_at) begin
                rst_ni = 1'b0;
                #1;
                chk("rst_valid", 64'(bus.valid_o), 64'd0);
                chk("rst_result", bus.result_o, 64'd0);
                chk("rst_tid", 64'(bus.trans_id_o), 64'd0);
                chk("rst_ready", 64'(bus.ready_o), 64'd1);
                @(posedge clk_i);
                #1;
                chk("rst_hold_valid", 64'(bus.valid_o), 64'd0);
                #1 rst_ni = 1'b1;
                return;
            end
            #1;
            last = (k == n + 1);
            chk("busy_ready", 64'(bus.ready_o), 64'd0);
            chk("valid", 64'(bus.valid_o), 64'(last));
            chk("result", bus.result_o, last ? exp : 64'd0);
            chk("trans_id", 64'(bus.trans_id_o), last ? 64'(tag) : 64'd0);
        end
    endtask

    initial begin
        logic [63:0] m;
        logic [63:0] a;
        int          n;
        int          f;
        int          r;
        bus.flush_i     = 1'b0;
        bus.valid_i     = 1'b0;
        bus.op_i        = 1'b0;
        bus.operand_a_i = '0;
        bus.mask_i      = '0;
        bus.trans_id_i  = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        bus.valid_i = 1'b1;
        #1;
        chk("reset_ready", 64'(bus.ready_o), 64'd1);
        chk("reset_valid", 64'(bus.valid_o), 64'd0);
        chk("reset_result", bus.result_o, 64'd0);
        chk("reset_tid", 64'(bus.trans_id_o), 64'd0);
        @(posedge clk_i);
        #1;
        chk("reset_no_accept", 64'(bus.valid_o), 64'd0);
        bus.valid_i = 1'b0;
        rst_ni = 1'b1;

        run_op(1'b0, 64'h00000000000000F0, 64'h0000000000000FF0, 3'd2, 0, 0, 1'b1, 64'h000000000000000F);
        run_op(1'b1, 64'h0000000000000003, 64'h8000000000000001, 3'd5, 0, 0, 1'b1, 64'h8000000000000001);
        run_op(1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 3'd1, 0, 0, 1'b1, 64'h0);
        run_op(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h0, 3'd6, 0, 0, 1'b1, 64'h0);
        run_op(1'b0, 64'hDEADBEEFCAFEF00D, 64'hFFFFFFFFFFFFFFFF, 3'd7, 0, 0, 1'b1, 64'hDEADBEEFCAFEF00D);
        run_op(1'b0, 64'hDEADBEEFCAFEF00D, 64'hFFFFFFFFFFFFFFFF, 3'd3, 5, 0, 1'b0, 64'h0);
        run_op(1'b1, 64'h0000000000000001, 64'h0000000000000010, 3'd4, 0, 0, 1'b1, 64'h0000000000000010);
        run_op(1'b0, 64'hDEADBEEFCAFEF00D, 64'hFFFFFFFFFFFFFFFF, 3'd0, 0, 10, 1'b0, 64'h0);
        run_op(1'b1, 64'h0123456789ABCDEF, 64'hF0F0F0F0F0F0F0F0, 3'd2, 0, 0, 1'b0, 64'h0);

        for (int i = 0; i < 60; i++) begin
            a = {$urandom, $urandom};
            m = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: m = m & {$urandom, $urandom} & {$urandom, $urandom};
                1: m = 64'd1 << $urandom_range(0, 63);
                2: m = m;
                3: m = m | ~({$urandom, $urandom} & {$urandom, $urandom});
                default: m = 64'd0;
            endcase
            n = $countones(m);
            f = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, n + 1)) : 0;
            r = (f == 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, n + 1)) : 0;
            run_op(1'($urandom_range(0, 1)), a, m, TB'($urandom), f, r, 1'b0, 64'h0);
        end

        @(negedge clk_i);
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        #1;
        chk("final_ready", 64'(bus.ready_o), 64'd1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bitmanip_seq.md
BITMANIP_SEQ -- requirements
Module: bitmanip_seq

Interface
REQ-001 The block SHALL have parameter TRANS_ID_BITS, default 3, giving the transaction-ID width.
REQ-002 The block SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port flush_i, input, 1 bit: abort the in-flight operation.
REQ-005 The block SHALL have port valid_i, input, 1 bit: request valid.
REQ-006 The block SHALL have port ready_o, output, 1 bit: able to accept a request.
REQ-007 The block SHALL have port op_i, input, 1 bit: 0 = BEXT (bit extract), 1 = BDEP (bit deposit).
REQ-008 The block SHALL have port operand_a_i, input, 64 bits: source data.
REQ-009 The block SHALL have port mask_i, input, 64 bits: selection mask.
REQ-010 The block SHALL have port trans_id_i, input, TRANS_ID_BITS: tag of the request.
REQ-011 The block SHALL have port valid_o, output, 1 bit: result valid, one-cycle pulse.
REQ-012 The block SHALL have port result_o, output, 64 bits: operation result.
REQ-013 The block SHALL have port trans_id_o, output, TRANS_ID_BITS: tag of the result.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-015 ready_o SHALL equal (state == IDLE) && !flush_i.
REQ-016 Acceptance SHALL occur on a rising edge where valid_i && ready_o; this is cycle 0.
REQ-017 On acceptance the block SHALL do all of the following:
- capture op_i, operand_a_i, mask_i and trans_id_i;
- clear the result accumulator and the bit counter cnt (7 bits);
- go to BUSY if mask_i != 0, else DONE.
REQ-018 Inputs other than flush_i SHALL be ignored outside acceptance cycles.
REQ-019 Each BUSY cycle SHALL process exactly one mask bit, as follows:
- p = index of the lowest set bit of the held mask;
- BEXT: acc[cnt] = a[p];
- BDEP: acc[p] = a[cnt];
- cnt increments;
- the held mask clears bit p (mask & (mask-1)).
REQ-020 BUSY SHALL go to DONE on the edge that processes the last set bit (mask becomes 0).
REQ-021 Total latency SHALL be popcount(mask_i)+1 cycles: valid_o is high in cycle N+1 (N = popcount), so the range is 1..65.
REQ-022 In DONE, valid_o SHALL be 1 unless flush_i is high; result_o = acc and trans_id_o = held tag.
REQ-023 DONE SHALL go to IDLE on the next edge unconditionally. There is no back-pressure: the consumer must take the result that cycle.
REQ-024 When valid_o is 0, result_o and trans_id_o SHALL be driven to 0.
REQ-025 flush_i high in any state SHALL force the next state to IDLE and suppress valid_o combinationally in that cycle.
REQ-026 While flush_i is high, no request SHALL be accepted.
REQ-027 The first request after a flush SHALL be accepted in the cycle following flush deassertion.
REQ-028 Result bits SHALL be handled as follows:
- result bits not written by the algorithm are 0;
- BEXT result bits at index >= N are 0;
- BDEP result bits outside the mask are 0.
REQ-029 Only one operation SHALL be in flight; ready_o is low from cycle 1 through cycle N+1 inclusive.

Reset
REQ-030 When rst_ni = 0, the block SHALL asynchronously set all of the following:
- state = IDLE;
- acc, held operands, held mask, cnt and tag = 0;
- valid_o = 0, result_o = 0, trans_id_o = 0, ready_o = 1 (when flush_i = 0).
REQ-031 Reset asserted mid-operation SHALL discard the operation with no valid_o, and the first post-reset edge with valid_i = 1 SHALL accept.

Verification
REQ-032 BEXT, a=0x00000000000000F0, mask=0x0000000000000FF0, tag=2 -> valid_o in cycle 9, result_o=0x000000000000000F, trans_id_o=2.
REQ-033 BDEP, a=0x0000000000000003, mask=0x8000000000000001 -> valid_o in cycle 3, result_o=0x8000000000000001.
REQ-034 mask=0, either op, a=0xFFFFFFFFFFFFFFFF -> valid_o in cycle 1, result_o=0, ready_o high again in cycle 2.
REQ-035 BEXT, mask=0xFFFFFFFFFFFFFFFF, a=0xDEADBEEFCAFEF00D -> ready_o low in cycles 1..65, valid_o in cycle 65, result_o=0xDEADBEEFCAFEF00D.
REQ-036 Same stimulus as REQ-035, flush_i high in cycle 5 -> no valid_o, ready_o high in cycle 6, a new BDEP a=1, mask=0x10 accepted in cycle 6 returns 0x10 in cycle 8.
REQ-037 rst_ni low in cycle 10 of REQ-035 -> valid_o=0, result_o=0 and ready_o=1 immediately; no valid_o is ever produced for that operation.
